// File: rtl/line_buffer_array_pkg.sv
// rtl/line_buffer_array_pkg.sv - shared constants and helpers for the line buffer and window generators
package line_buffer_array_pkg;

  localparam int LB_DATA_W_DEF    = 10;
  localparam int LB_IMG_WIDTH_DEF = 480;

  // Bits needed to index n items; never less than 1 so degenerate sizes stay legal.
  function automatic int lb_clog2(input int n);
    int r;
    int v;
    r = 0;
    v = n - 1;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return (r < 1) ? 1 : r;
  endfunction

  // LSB of tap k inside a packed column word.
  function automatic int tap_sel(input int k, input int data_w);
    return k * data_w;
  endfunction

endpackage

// File: rtl/line_buffer_array_colmem.sv
// rtl/line_buffer_array_colmem.sv - column-addressed line store, async read / sync write
module line_buffer_array_colmem #(
  parameter int WORD_W = 20,
  parameter int DEPTH  = 480,
  parameter int ADDR_W = 9
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  // No reset: contents are don't-care until the line counter shows them refilled.
  logic [WORD_W-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

endmodule

// File: rtl/line_buffer_array.sv
// rtl/line_buffer_array.sv - multi-line buffer emitting NUM_LINES+1 pixel columns; option LB_BORDER_REPLICATE_EN
module line_buffer_array
  import line_buffer_array_pkg::*;
#(
  parameter int DATA_W    = LB_DATA_W_DEF,
  parameter int IMG_WIDTH = LB_IMG_WIDTH_DEF,
  parameter int NUM_LINES = 2,
  parameter int CNT_W     = 12
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            sof,
  input  logic                            valid_in,
  input  logic [DATA_W-1:0]               din,
  output logic                            valid_out,
  output logic [DATA_W*(NUM_LINES+1)-1:0] dout_col,
  output logic [CNT_W-1:0]                col_out,
  output logic                            eol_out
);

  localparam int ADDR_W = lb_clog2(IMG_WIDTH);
  localparam int LF_W   = lb_clog2(NUM_LINES + 1);
  localparam int MEM_W  = DATA_W * NUM_LINES;
  localparam int COL_W  = DATA_W * (NUM_LINES + 1);
  localparam logic [CNT_W-1:0] COL_LAST = CNT_W'(IMG_WIDTH - 1);
  localparam logic [LF_W-1:0]  LF_FULL  = LF_W'(NUM_LINES);

  logic [CNT_W-1:0] col_q, col_d;
  logic [LF_W-1:0]  lf_q, lf_d;
  logic             valid_out_q, valid_out_d;
  logic [COL_W-1:0] dout_col_q, dout_col_d;
  logic [CNT_W-1:0] col_out_q, col_out_d;
  logic             eol_out_q, eol_out_d;

  logic [CNT_W-1:0] ec;
  logic [LF_W-1:0]  lf_eff;
  logic             last_col;
  logic [MEM_W-1:0] rd_word;
  logic [MEM_W-1:0] wr_word;
  logic [COL_W-1:0] col_word;
  logic [COL_W-1:0] tap_word;
  logic             valid_next;

  // sof restarts the frame on the very pixel that carries it.
  assign ec       = sof ? '0 : col_q;
  assign lf_eff   = sof ? '0 : lf_q;
  assign last_col = (ec == COL_LAST);
  assign col_word = {rd_word, din};

  generate
    if (NUM_LINES == 1) begin : g_wr_single
      assign wr_word = din;
    end else begin : g_wr_shift
      assign wr_word = {rd_word[MEM_W-DATA_W-1:0], din};
    end
  endgenerate

  line_buffer_array_colmem #(
    .WORD_W (MEM_W),
    .DEPTH  (IMG_WIDTH),
    .ADDR_W (ADDR_W)
  ) u_colmem (
    .clk   (clk),
    .we    (valid_in),
    .addr  (ec[ADDR_W-1:0]),
    .wdata (wr_word),
    .rdata (rd_word)
  );

`ifdef LB_BORDER_REPLICATE_EN
  // Lines not yet filled take the topmost valid line instead of stale memory.
  always_comb begin
    tap_word   = col_word;
    valid_next = valid_in;
    for (int k = 1; k <= NUM_LINES; k++) begin
      if (LF_W'(k) > lf_eff) begin
        tap_word[tap_sel(k, DATA_W) +: DATA_W] = col_word[int'(lf_eff) * DATA_W +: DATA_W];
      end
    end
  end
`else
  always_comb begin
    tap_word   = col_word;
    valid_next = valid_in && (lf_eff == LF_FULL);
  end
`endif

  always_comb begin
    col_d       = col_q;
    lf_d        = lf_q;
    valid_out_d = valid_next;
    dout_col_d  = dout_col_q;
    col_out_d   = col_out_q;
    eol_out_d   = eol_out_q;
    if (valid_in) begin
      dout_col_d = tap_word;
      col_out_d  = ec;
      eol_out_d  = last_col;
      col_d      = last_col ? '0 : ec + 1'b1;
      lf_d       = (last_col && (lf_eff != LF_FULL)) ? lf_eff + 1'b1 : lf_eff;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q       <= '0;
      lf_q        <= '0;
      valid_out_q <= 1'b0;
      dout_col_q  <= '0;
      col_out_q   <= '0;
      eol_out_q   <= 1'b0;
    end else begin
      col_q       <= col_d;
      lf_q        <= lf_d;
      valid_out_q <= valid_out_d;
      dout_col_q  <= dout_col_d;
      col_out_q   <= col_out_d;
      eol_out_q   <= eol_out_d;
    end
  end

  assign valid_out = valid_out_q;
  assign dout_col  = dout_col_q;
  assign col_out   = col_out_q;
  assign eol_out   = eol_out_q;

endmodule

// File: tb/tb_line_buffer_array.sv
// tb/tb_line_buffer_array.sv - scoreboard bench for line_buffer_array (IMG_WIDTH=4, NUM_LINES=2)
module tb_line_buffer_array;

  localparam int DW = 10;
  localparam int W  = 4;
  localparam int NL = 2;
  localparam int CW = 4;
  localparam int TW = DW * (NL + 1);
`ifdef LB_BORDER_REPLICATE_EN
  localparam bit REPL = 1'b1;
`else
  localparam bit REPL = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          sof = 1'b0;
  logic          valid_in = 1'b0;
  logic [DW-1:0] din = '0;
  logic          valid_out;
  logic [TW-1:0] dout_col;
  logic [CW-1:0] col_out;
  logic          eol_out;

  line_buffer_array #(
    .DATA_W    (DW),
    .IMG_WIDTH (W),
    .NUM_LINES (NL),
    .CNT_W     (CW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .sof       (sof),
    .valid_in  (valid_in),
    .din       (din),
    .valid_out (valid_out),
    .dout_col  (dout_col),
    .col_out   (col_out),
    .eol_out   (eol_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [TW-1:0] col;
    logic [CW-1:0] x;
    logic          eol;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Monitor: every emitted column must match the oldest outstanding expectation.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && valid_out) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_valid: valid_out=1 col_out=%0d dout_col=%0h, expected no output", col_out, dout_col);
      end else begin
        e = exp_q.pop_front();
        check("dout_col", 64'(dout_col), 64'(e.col));
        check("col_out_eol", 64'({col_out, eol_out}), 64'({e.x, e.eol}));
      end
    end
  end

  task automatic drive(input bit s, input logic [DW-1:0] d);
    sof = s;
    valid_in = 1'b1;
    din = d;
    @(posedge clk);
    #1;
    sof = 1'b0;
    valid_in = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Pixel i of a fresh segment sits on line i/W; tap k is the pixel k lines up,
  // i.e. din - W*k, clamped to the topmost filled line when replicating.
  task automatic run_seg(input int base, input int n, input bit first_sof, input bit bubbles);
    exp_t e;
    int   line;
    int   lf;
    int   kk;
    for (int i = 0; i < n; i++) begin
      line = i / W;
      lf = (line < NL) ? line : NL;
      if (REPL || lf == NL) begin
        e.col = '0;
        for (int k = 0; k <= NL; k++) begin
          kk = (k < lf) ? k : lf;
          e.col[k*DW +: DW] = DW'(base + i - W * kk);
        end
        e.x = CW'(i % W);
        e.eol = ((i % W) == W - 1);
        exp_q.push_back(e);
      end
      drive(first_sof && (i == 0), DW'(base + i));
      if (bubbles) idle(1);
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_valid_out", 64'(valid_out), 64'(0));
    check("rst_dout_col", 64'(dout_col), 64'(0));
    check("rst_col_out", 64'(col_out), 64'(0));
    check("rst_eol_out", 64'(eol_out), 64'(0));
    rst_n = 1'b1;
    idle(1);

    run_seg(0, 12, 1'b1, 1'b0);
    idle(2);
    run_seg(100, 12, 1'b1, 1'b1);
    idle(2);
    run_seg(200, 10, 1'b1, 1'b0);
    run_seg(210, 12, 1'b1, 1'b0);
    idle(2);

    run_seg(300, 6, 1'b1, 1'b0);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid_out", 64'(valid_out), 64'(0));
    check("async_rst_dout_col", 64'(dout_col), 64'(0));
    check("async_rst_col_out", 64'(col_out), 64'(0));
    check("async_rst_eol_out", 64'(eol_out), 64'(0));
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_seg(310, 12, 1'b0, 1'b0);
    idle(3);

    check("queue_drained", 64'(exp_q.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
